// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned shift-and-add multiplier. A start strobe in IDLE
//   captures two SIZE-bit operands. Each RUN cycle adds the shifted
//   multiplicand into the accumulator when the current multiplier LSB is set,
//   then shifts the multiplicand left and the multiplier right. RUN ends early
//   once the remaining multiplier bits are all zero.
//
//   Handshake: start is sampled only in IDLE and is ignored while busy=1,
//   including the DONE cycle. There is no queueing. done pulses for exactly
//   one cycle (the DONE state), and product/ovf are valid in that cycle and
//   hold until the next result or reset.
//
// Ports
//   clk           rising-edge system clock
//   reset         asynchronous, active-high; clears all state and outputs
//   start         request, sampled only in IDLE
//   multiplicand  operand A, captured on the accepting edge
//   multiplier    operand B, captured on the accepting edge
//   product       registered 2*SIZE-bit result
//   busy          high in every state except IDLE
//   done          one-cycle pulse that marks product as valid
//   ovf           product upper half is non-zero, registered with product
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic [2*SIZE-1:0] product,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  // LOAD is the cycle after the accepting edge. The zero-operand check is made
  // there on the captured registers, which gives DONE after edge N+1 for a
  // non-zero pair and after edge 1 when either operand is zero.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*SIZE-1:0] mcand_sh;
  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] acc_add;
  logic [SIZE-1:0]   mplier_sh;
  logic [SIZE-1:0]   mplier_shr;
  logic [CW-1:0]     cnt;
  logic              run_last;
  logic              zero_op;

  // Datapath helpers for the current RUN step.
  always_comb begin
    acc_add    = mplier_sh[0] ? (acc + mcand_sh) : acc;
    mplier_shr = mplier_sh >> 1;
    // cnt bound only matters if the multiplier MSB was set; it keeps the
    // loop finite regardless of the shift-out condition.
    run_last   = (mplier_shr == '0) || (cnt == CW'(SIZE - 1));
    zero_op    = (mcand_sh == '0) || (mplier_sh == '0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = zero_op ? DONE : RUN;
      RUN:     if (run_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status decoded straight from the state flops.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Operand, accumulator and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_sh  <= '0;
      mplier_sh <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_sh  <= {{SIZE{1'b0}}, multiplicand};
            mplier_sh <= multiplier;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        LOAD: begin
          if (zero_op) begin
            product <= '0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          acc       <= acc_add;
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_shr;
          cnt       <= cnt + CW'(1);
          // Result is committed on the same edge that enters DONE and
          // includes this final partial add.
          if (run_last) begin
            product <= acc_add;
            ovf     <= |acc_add[2*SIZE-1:SIZE];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
